// File: rtl/demo_rsp_if.sv
// Request/response bundle between a demo channel driver and the response engine.
// The driver holds the master modport; the engine holds the slave modport.
interface demo_rsp_if #(
  parameter int addr_i_width = 8,
  parameter int data_i_width = 16,
  parameter int addr_o_width = 8,
  parameter int data_o_width = 16,
  parameter int depth        = 4
);
  localparam int fill_width = $clog2(depth + 1);

  logic                    vld_i;
  logic [addr_i_width-1:0] addr_i;
  logic [data_i_width-1:0] data_i;
  logic                    hold_i;
  logic                    vld_o;
  logic [addr_o_width-1:0] addr_o;
  logic [data_o_width-1:0] data_o;
  logic [3:0]              result;
  logic [fill_width-1:0]   fill_o;

  modport master (
    output vld_i, addr_i, data_i, hold_i,
    input  vld_o, addr_o, data_o, result, fill_o
  );

  modport slave (
    input  vld_i, addr_i, data_i, hold_i,
    output vld_o, addr_o, data_o, result, fill_o
  );
endinterface

// File: rtl/demo_rsp_engine.sv
// Responder: buffers single-cycle requests in a FIFO, converts widths and
// emits paced responses with a 4-bit status code.
module demo_rsp_engine #(
  parameter int addr_i_width = 8,
  parameter int data_i_width = 16,
  parameter int addr_o_width = 8,
  parameter int data_o_width = 16,
  parameter int depth        = 4,
  parameter int gap          = 0
) (
  input logic      clk,
  input logic      rst,
  demo_rsp_if.slave bus
);
  localparam int fill_width  = $clog2(depth + 1);
  localparam int ptr_width   = $clog2(depth);
  localparam int cnt_width   = (gap > 0) ? $clog2(gap + 1) : 1;
  localparam int entry_width = addr_i_width + data_i_width;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t                  state, state_nxt;
  logic [cnt_width-1:0]    cnt, cnt_nxt;
  logic [entry_width-1:0]  mem [depth];
  logic [ptr_width-1:0]    wr_ptr, rd_ptr;
  logic [fill_width-1:0]   fill;
  logic                    drop_flag;
  logic                    empty, full, avail, slot_ok, launch;
  logic                    push, pop, drop;
  logic [addr_i_width-1:0] src_addr;
  logic [data_i_width-1:0] src_data;
  logic [addr_o_width-1:0] conv_addr;
  logic [data_o_width-1:0] conv_data;
  logic                    addr_trunc, data_sat;

  assign empty = (fill == '0);
  assign full  = (fill == fill_width'(depth));
  assign avail = !empty || bus.vld_i;

  // An empty FIFO lets the incoming request go straight to the output stage.
  assign {src_addr, src_data} = empty ? {bus.addr_i, bus.data_i} : mem[rd_ptr];

  assign pop  = launch && !empty;
  assign push = bus.vld_i && !(launch && empty) && (!full || pop);
  assign drop = bus.vld_i && full && !pop;

  generate
    if (addr_o_width >= addr_i_width) begin : g_addr_ext
      assign conv_addr  = addr_o_width'(src_addr);
      assign addr_trunc = 1'b0;
    end else begin : g_addr_cut
      assign conv_addr  = src_addr[addr_o_width-1:0];
      assign addr_trunc = |src_addr[addr_i_width-1:addr_o_width];
    end

    if (data_o_width >= data_i_width) begin : g_data_ext
      assign conv_data = data_o_width'(src_data);
      assign data_sat  = 1'b0;
    end else begin : g_data_sat
      assign data_sat  = |src_data[data_i_width-1:data_o_width];
      assign conv_data = data_sat ? '1 : src_data[data_o_width-1:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // GAP loads the full gap count; the cycle where it would reach zero is
  // already a launch slot, giving exactly `gap` idle cycles between pulses.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    slot_ok   = 1'b0;
    case (state)
      IDLE:    slot_ok = 1'b1;
      SEND:    slot_ok = (gap == 0);
      GAP:     slot_ok = (cnt == cnt_width'(1));
      default: slot_ok = 1'b1;
    endcase
    launch = slot_ok && !bus.hold_i && avail;
    if (launch) begin
      state_nxt = SEND;
    end else begin
      case (state)
        SEND: begin
          if (gap > 0) begin
            state_nxt = GAP;
            cnt_nxt   = cnt_width'(gap);
          end else begin
            state_nxt = IDLE;
          end
        end
        GAP: begin
          if (cnt == cnt_width'(1)) state_nxt = IDLE;
          else                      cnt_nxt   = cnt - 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.addr_i, bus.data_i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill       <= '0;
      drop_flag  <= 1'b0;
      bus.vld_o  <= 1'b0;
      bus.addr_o <= '0;
      bus.data_o <= '0;
      bus.result <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
      bus.vld_o <= launch;
      if (launch) begin
        bus.addr_o <= conv_addr;
        bus.data_o <= conv_data;
        bus.result <= {^conv_data, drop_flag, data_sat, addr_trunc};
        // A drop coinciding with this launch belongs to the next response.
        drop_flag  <= drop;
      end else begin
        drop_flag  <= drop_flag | drop;
      end
    end
  end

  assign bus.fill_o = fill;
endmodule
